// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one RAM port between an instruction fetch requester and a data
//   requester. Data wins by default. A streak counter (dstreak) bounds how
//   many data grants can pass a waiting fetch. Once the streak reaches
//   STARVE_MAX, the next grant goes to the fetch.
//
// Handshake: a requester raises its request (iREN, or dREN/dWEN) and holds it
//   with stable address/data until its wait output is low. Wait low while the
//   request is high marks completion in that same cycle. For a read, the load
//   word is valid only in that cycle. A requester may drop an ungranted or
//   granted-but-incomplete request at any time, for example on a fetch flush.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN, iaddr           instruction fetch request / address
//   iload, iwait          instruction read word / not-yet-complete
//   dREN, dWEN            data read / write request (both high = write)
//   daddr, dstore         data address / write word
//   dload, dwait          data read word / not-yet-complete
//   ramREN, ramWEN        RAM strobes (from state + latched direction only)
//   ramaddr, ramstore     registered RAM address / write word
//   ramload, ramstate     RAM read word / status (FREE, BUSY, ACCESS, ERROR)
//   dbg_state             current FSM state (IDLE=0, DGRANT=1, IGRANT=2)
//   dbg_dstreak           current data-grant streak count
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              iREN,
  input  logic [ADDR_W-1:0]                 iaddr,
  output logic [ADDR_W-1:0]                 iload,
  output logic                              iwait,
  input  logic                              dREN,
  input  logic                              dWEN,
  input  logic [ADDR_W-1:0]                 daddr,
  input  logic [ADDR_W-1:0]                 dstore,
  output logic [ADDR_W-1:0]                 dload,
  output logic                              dwait,
  output logic                              ramREN,
  output logic                              ramWEN,
  output logic [ADDR_W-1:0]                 ramaddr,
  output logic [ADDR_W-1:0]                 ramstore,
  input  logic [ADDR_W-1:0]                 ramload,
  input  logic [1:0]                        ramstate,
  output logic [1:0]                        dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_dstreak
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(STARVE_MAX);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   dstreak_q, dstreak_d;
  logic [ADDR_W-1:0]  ramaddr_q, ramaddr_d;
  logic [ADDR_W-1:0]  ramstore_q, ramstore_d;
  logic               dir_write_q, dir_write_d;

  logic d_req;
  logic starve;
  logic access;
  logic i_done;
  logic d_done;

  assign d_req  = dREN | dWEN;
  assign starve = iREN && (dstreak_q == STREAK_MAX);
  assign access = (ramstate == RS_ACCESS);

  // Next-state and datapath latching
  always_comb begin
    state_d     = state_q;
    dstreak_d   = dstreak_q;
    ramaddr_d   = ramaddr_q;
    ramstore_d  = ramstore_q;
    dir_write_d = dir_write_q;
    case (state_q)
      IDLE: begin
        if (d_req && !starve) begin
          state_d     = DGRANT;
          ramaddr_d   = daddr;
          ramstore_d  = dstore;
          // Simultaneous dREN and dWEN resolves to a write.
          dir_write_d = dWEN;
          if (!iREN) begin
            dstreak_d = '0;
          end else if (dstreak_q != STREAK_MAX) begin
            dstreak_d = dstreak_q + CNT_W'(1);
          end
        end else if (iREN) begin
          state_d     = IGRANT;
          ramaddr_d   = iaddr;
          ramstore_d  = '0;
          dir_write_d = 1'b0;
          dstreak_d   = '0;
        end
      end
      // BUSY/FREE hold; ERROR holds too, so the same access is reissued.
      // A dropped request (flush) abandons the grant without touching dstreak.
      DGRANT: if (!d_req || access) state_d = IDLE;
      IGRANT: if (!iREN  || access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      dstreak_q   <= '0;
      ramaddr_q   <= '0;
      ramstore_q  <= '0;
      dir_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dstreak_q   <= dstreak_d;
      ramaddr_q   <= ramaddr_d;
      ramstore_q  <= ramstore_d;
      dir_write_q <= dir_write_d;
    end
  end

  // Outputs: strobes depend only on registered state and direction.
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    i_done = 1'b0;
    d_done = 1'b0;
    iload  = '0;
    dload  = '0;
    case (state_q)
      IGRANT: begin
        ramREN = 1'b1;
        i_done = access && iREN;
      end
      DGRANT: begin
        ramREN = !dir_write_q;
        ramWEN = dir_write_q;
        d_done = access && d_req;
      end
      default: ;
    endcase
    if (i_done)                 iload = ramload;
    if (d_done && !dir_write_q) dload = ramload;
    iwait = iREN  && !i_done;
    dwait = d_req && !d_done;
  end

  assign ramaddr     = ramaddr_q;
  assign ramstore    = ramstore_q;
  assign dbg_state   = state_q;
  assign dbg_dstreak = dstreak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_ren;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_dstreak;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_DG = 2'd1, S_IG = 2'd2;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACC = 2'd2, R_ERR = 2'd3;

  mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK(clk), .RST(rst),
    .iREN(i_ren), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(d_ren), .dWEN(d_wen), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .dbg_state(dbg_state), .dbg_dstreak(dbg_dstreak)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [1:0]  exp_st [7] = '{S_DG, S_DG, S_DG, S_DG, S_IG, S_DG, S_DG};
  logic [2:0]  exp_sk [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2};

  initial begin
    rst = 1'b1; i_ren = 0; iaddr = '0; d_ren = 0; d_wen = 0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Reset state
    mid();
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_ramren", 32'(ram_ren), 0);
    check("rst_ramwen", 32'(ram_wen), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", 32'(iwait), 0);
    check("rst_dwait", 32'(dwait), 0);
    check("rst_streak", 32'(dbg_dstreak), 0);
    next_cycle();

    // Fetch only: two BUSY cycles then ACCESS
    i_ren = 1; iaddr = 32'h100; ramstate = R_BUSY;
    mid();
    check("f_idle_state", 32'(dbg_state), 32'(S_IDLE));
    check("f_idle_iwait", 32'(iwait), 1);
    check("f_idle_ramren", 32'(ram_ren), 0);
    next_cycle();
    mid();
    check("f_c1_state", 32'(dbg_state), 32'(S_IG));
    check("f_c1_ramren", 32'(ram_ren), 1);
    check("f_c1_ramwen", 32'(ram_wen), 0);
    check("f_c1_ramaddr", ramaddr, 32'h100);
    check("f_c1_iwait", 32'(iwait), 1);
    check("f_c1_iload", iload, 0);
    next_cycle();
    mid();
    check("f_c2_state", 32'(dbg_state), 32'(S_IG));
    check("f_c2_ramren", 32'(ram_ren), 1);
    check("f_c2_iwait", 32'(iwait), 1);
    next_cycle();
    ramstate = R_ACC; ramload = 32'hDEADBEEF;
    mid();
    check("f_acc_iwait", 32'(iwait), 0);
    check("f_acc_iload", iload, 32'hDEADBEEF);
    check("f_acc_ramren", 32'(ram_ren), 1);
    next_cycle();
    i_ren = 0; ramstate = R_FREE; ramload = '0;
    mid();
    check("f_done_state", 32'(dbg_state), 32'(S_IDLE));
    check("f_done_ramren", 32'(ram_ren), 0);
    check("f_done_iload", iload, 0);
    next_cycle();

    // Contention: data write wins, fetch follows after one IDLE cycle
    i_ren = 1; iaddr = 32'h300; d_wen = 1; daddr = 32'h200; dstore = 32'h5;
    mid();
    check("c_idle_iwait", 32'(iwait), 1);
    check("c_idle_dwait", 32'(dwait), 1);
    next_cycle();
    mid();
    check("c_dg_state", 32'(dbg_state), 32'(S_DG));
    check("c_dg_ramwen", 32'(ram_wen), 1);
    check("c_dg_ramren", 32'(ram_ren), 0);
    check("c_dg_ramaddr", ramaddr, 32'h200);
    check("c_dg_ramstore", ramstore, 32'h5);
    check("c_dg_streak", 32'(dbg_dstreak), 1);
    check("c_dg_iwait", 32'(iwait), 1);
    next_cycle();
    ramstate = R_ACC; ramload = 32'hFFFF0000;
    mid();
    check("c_acc_dwait", 32'(dwait), 0);
    check("c_acc_dload", dload, 0);
    check("c_acc_iwait", 32'(iwait), 1);
    next_cycle();
    d_wen = 0; ramstate = R_FREE;
    mid();
    check("c_turn_state", 32'(dbg_state), 32'(S_IDLE));
    check("c_turn_ramwen", 32'(ram_wen), 0);
    next_cycle();
    ramstate = R_ACC; ramload = 32'h12345678;
    mid();
    check("c_ig_state", 32'(dbg_state), 32'(S_IG));
    check("c_ig_ramaddr", ramaddr, 32'h300);
    check("c_ig_ramstore", ramstore, 0);
    check("c_ig_streak", 32'(dbg_dstreak), 0);
    check("c_ig_iwait", 32'(iwait), 0);
    check("c_ig_iload", iload, 32'h12345678);
    next_cycle();
    i_ren = 0; ramstate = R_FREE;
    mid();
    check("c_end_state", 32'(dbg_state), 32'(S_IDLE));
    next_cycle();

    // Starvation: fetch held against back-to-back data reads
    i_ren = 1; iaddr = 32'h400; d_ren = 1; daddr = 32'h800;
    for (int k = 0; k < 7; k++) begin
      ramstate = R_FREE;
      mid();
      check($sformatf("s%0d_idle", k), 32'(dbg_state), 32'(S_IDLE));
      next_cycle();
      ramstate = R_ACC; ramload = 32'hA0000000 + 32'(k);
      mid();
      check($sformatf("s%0d_state", k), 32'(dbg_state), 32'(exp_st[k]));
      check($sformatf("s%0d_streak", k), 32'(dbg_dstreak), 32'(exp_sk[k]));
      if (exp_st[k] == S_DG) begin
        check($sformatf("s%0d_dload", k), dload, 32'hA0000000 + 32'(k));
        check($sformatf("s%0d_iwait", k), 32'(iwait), 1);
      end else begin
        check($sformatf("s%0d_iload", k), iload, 32'hA0000000 + 32'(k));
        check($sformatf("s%0d_dwait", k), 32'(dwait), 1);
      end
      next_cycle();
    end
    i_ren = 0; d_ren = 0; ramstate = R_FREE;
    mid();
    check("s_end_streak", 32'(dbg_dstreak), 2);
    next_cycle();

    // Flush of an in-flight fetch, then a data read granted from IDLE
    i_ren = 1; iaddr = 32'h500; ramstate = R_BUSY;
    mid();
    next_cycle();
    mid();
    check("fl_ig_state", 32'(dbg_state), 32'(S_IG));
    check("fl_ig_streak", 32'(dbg_dstreak), 0);
    next_cycle();
    i_ren = 0;
    mid();
    check("fl_drop_iwait", 32'(iwait), 0);
    check("fl_drop_iload", iload, 0);
    next_cycle();
    d_ren = 1; daddr = 32'h600; i_ren = 1; iaddr = 32'h700;
    mid();
    check("fl_idle_state", 32'(dbg_state), 32'(S_IDLE));
    check("fl_idle_ramren", 32'(ram_ren), 0);
    check("fl_idle_dwait", 32'(dwait), 1);
    next_cycle();

    // Error retry for three cycles, then reset mid-grant
    ramstate = R_ERR;
    for (int e = 0; e < 3; e++) begin
      mid();
      check($sformatf("er%0d_state", e), 32'(dbg_state), 32'(S_DG));
      check($sformatf("er%0d_ramren", e), 32'(ram_ren), 1);
      check($sformatf("er%0d_ramwen", e), 32'(ram_wen), 0);
      check($sformatf("er%0d_ramaddr", e), ramaddr, 32'h600);
      check($sformatf("er%0d_dwait", e), 32'(dwait), 1);
      check($sformatf("er%0d_dload", e), dload, 0);
      check($sformatf("er%0d_streak", e), 32'(dbg_dstreak), 1);
      next_cycle();
    end
    rst = 1; ramstate = R_BUSY;
    mid();
    next_cycle();
    mid();
    check("r_state", 32'(dbg_state), 32'(S_IDLE));
    check("r_ramren", 32'(ram_ren), 0);
    check("r_ramwen", 32'(ram_wen), 0);
    check("r_streak", 32'(dbg_dstreak), 0);
    check("r_ramaddr", ramaddr, 0);
    check("r_dwait", 32'(dwait), 1);
    check("r_iwait", 32'(iwait), 1);
    next_cycle();
    rst = 0;
    mid();
    check("r_prio_state", 32'(dbg_state), 32'(S_IDLE));
    next_cycle();
    ramstate = R_ACC; ramload = 32'h0BADF00D;
    mid();
    check("r_regrant_state", 32'(dbg_state), 32'(S_DG));
    check("r_regrant_ramaddr", ramaddr, 32'h600);
    check("r_regrant_streak", 32'(dbg_dstreak), 1);
    check("r_regrant_dload", dload, 32'h0BADF00D);
    check("r_regrant_dwait", 32'(dwait), 0);
    next_cycle();
    d_ren = 0; i_ren = 0; ramstate = R_FREE;
    mid();
    check("r_end_state", 32'(dbg_state), 32'(S_IDLE));
    next_cycle();

    // dREN and dWEN together behave as a write
    d_ren = 1; d_wen = 1; daddr = 32'h900; dstore = 32'h77;
    mid();
    next_cycle();
    ramstate = R_ACC; ramload = 32'h55555555;
    mid();
    check("w_state", 32'(dbg_state), 32'(S_DG));
    check("w_ramwen", 32'(ram_wen), 1);
    check("w_ramren", 32'(ram_ren), 0);
    check("w_ramstore", ramstore, 32'h77);
    check("w_streak", 32'(dbg_dstreak), 0);
    check("w_dwait", 32'(dwait), 0);
    check("w_dload", dload, 0);
    next_cycle();
    d_ren = 0; d_wen = 0; ramstate = R_FREE;
    mid();
    check("w_end_state", 32'(dbg_state), 32'(S_IDLE));
    check("w_end_dwait", 32'(dwait), 0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the maximum consecutive data grants issued while an instruction request waits.
REQ-002 SHALL have parameter ADDR_W, default 32, the width of addresses and data words.
REQ-003 CLK  in  1  system clock; single clock domain; all state updates on the rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 iREN  in  1  instruction fetch request; held by the requester until iwait is low.
REQ-006 iaddr  in  ADDR_W  instruction fetch address.
REQ-007 iload  out  ADDR_W  instruction read data.
REQ-008 iwait  out  1  instruction request not yet complete.
REQ-009 dREN / dWEN  in  1 each  data read / data write request; held until dwait is low.
REQ-010 daddr / dstore  in  ADDR_W each  data address / data write word.
REQ-011 dload  out  ADDR_W  data read word.
REQ-012 dwait  out  1  data request not yet complete.
REQ-013 ramREN / ramWEN  out  1 each  RAM read / RAM write strobe.
REQ-014 ramaddr / ramstore  out  ADDR_W each  RAM address / RAM write data, both registered.
REQ-015 ramload  in  ADDR_W  RAM read data.
REQ-016 ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-017 SHALL implement three states: IDLE, DGRANT and IGRANT.
REQ-018 In IDLE, a pending request SHALL cause a grant that moves the block to DGRANT or IGRANT on the next edge.
- At that edge, ramaddr and ramstore SHALL latch the granted address and data.
- Any dWEN/dREN requests DGRANT; a latched dWEN drives ramWEN, otherwise the grant drives ramREN.
REQ-019 Grant priority SHALL be data over instruction, except that IGRANT SHALL be chosen when iREN is high and dstreak equals STARVE_MAX.
REQ-020 The dstreak counter SHALL behave as follows:
- increments by 1 on each data grant while iREN is high;
- clears on any instruction grant;
- clears on any data grant while iREN is low;
- saturates at STARVE_MAX;
- width is $clog2(STARVE_MAX+1).
REQ-021 dREN and dWEN high together SHALL be treated as a write.
REQ-022 ramREN and ramWEN SHALL be driven only from the current state and the latched direction, never from the requester inputs in the same cycle.
- Both SHALL be 0 in IDLE.
- At most one SHALL be high in any cycle.
REQ-023 In DGRANT or IGRANT with ramstate==ACCESS, the granted wait output SHALL be low in that same cycle.
- For a granted read, ramload SHALL pass combinationally to iload or dload in that cycle.
- The state SHALL return to IDLE on the next edge.
REQ-024 ramstate BUSY or FREE while granted SHALL hold the state, the strobes, ramaddr and ramstore unchanged.
REQ-025 ramstate ERROR while granted SHALL keep the grant and reissue the same access: strobes stay high, wait stays high.
REQ-026 If the granted request drops before ACCESS (iREN low in IGRANT, or dREN and dWEN low in DGRANT), the block SHALL return to IDLE on the next edge.
- Strobes SHALL be 0 from that edge on.
- dstreak SHALL be unchanged.
- This covers branch/jump flushes of an in-flight fetch.
REQ-027 A wait output SHALL be high whenever its request is high and it is not completing that cycle.
- Its wait SHALL be 0 when its request is low.
- The non-granted requester's wait SHALL stay high while its request is high.
REQ-028 iload and dload SHALL be 0 when not completing a read.
REQ-029 Minimum spacing SHALL be one turnaround cycle: a request in IDLE at cycle n can first see ACCESS at cycle n+1, and the next grant registers at n+2.

Reset
REQ-030 With RST high at an edge, the block SHALL enter IDLE with dstreak=0, ramaddr=0 and ramstore=0; ramREN, ramWEN, iload and dload SHALL be 0, and iwait and dwait SHALL follow REQ-027.
REQ-031 RST asserted mid-transaction SHALL abandon the access with no completion signalled; the requester SHALL re-present the request after reset.
REQ-032 RST SHALL take priority over every other event in the same cycle.

Verification
REQ-033 Fetch only: iREN=1, iaddr=0x100, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1 with ramaddr=0x100 from cycle 1; iwait=0 and iload=0xDEADBEEF in the ACCESS cycle; IDLE next cycle.
REQ-034 Contention: iREN=1 and dWEN=1 (daddr=0x200, dstore=0x5) in the same IDLE cycle -> DGRANT with ramWEN=1 and ramstore=0x5; IGRANT follows the data ACCESS after one IDLE cycle.
REQ-035 Starvation: iREN held with back-to-back dREN for 6 transactions, STARVE_MAX=4 -> 4 data grants, then 1 instruction grant, then data resumes; dstreak reads 0 after the instruction grant.
REQ-036 Flush: IGRANT in progress with ramstate BUSY, then iREN drops -> IDLE next cycle with ramREN=0; a dREN presented that cycle is granted on the following edge.
REQ-037 Error retry plus reset: ramstate ERROR for 3 cycles during DGRANT -> ramREN held, dwait=1 throughout; RST=1 mid-grant -> IDLE, strobes 0, dstreak=0 on the next cycle.
